rx_operand_loader: RTL and testbench
====================================

# rx_operand_loader

Receive-side companion to the UART test sequencer: consumes bytes from the UART receiver, waits for a sync byte, assembles groups of bytes into operand words and writes them sequentially into the operand memory feeding the CORDIC core. When the last address is written it raises `load_done` and holds it until the downstream sequencer acknowledges, then re-arms for the next frame. An inter-byte timeout discards partial frames so a dropped byte cannot misalign later frames.

## Interface
- `WORD_W`, 32: operand width; must be a multiple of 8; `BYTES_PER_WORD = WORD_W/8`.
- `ADDR_W`, 4: write address width.
- `NUM_WORDS`, 16: words per frame, 1..2^ADDR_W.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYC`, 100000: idle clocks allowed between bytes inside a frame.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_done_tick` in 1: one-cycle strobe, `rx_data` valid.
- `rx_data` in 8: received byte.
- `load_ack` in 1: level; consumer has taken the frame.
- `wr_en` out 1: one-cycle memory write strobe.
- `wr_addr` out ADDR_W: write address.
- `wr_data` out WORD_W: write data.
- `load_done` out 1: frame complete, held until ack.
- `frame_err` out 1: one-cycle pulse on timeout.

## Operation
- All outputs registered; reset value 0 for every output, address counter, byte counter, timer; state IDLE.
- States:
  - IDLE: bytes other than `SYNC_BYTE` ignored; `SYNC_BYTE` -> SHIFT, byte count 0, address 0, timer cleared.
  - SHIFT: each tick shifts `rx_data` in; first byte of a word is the MSB. On byte `BYTES_PER_WORD-1`, load assembled word into `wr_data` -> WRITE.
  - WRITE: one cycle, `wr_en`=1; address increments at end of cycle. If the written address was `NUM_WORDS-1` -> DONE, else -> SHIFT.
  - DONE: `load_done`=1; ticks ignored; `load_ack`=1 -> IDLE next cycle, `load_done` drops with it.
- Bytes equal to `SYNC_BYTE` inside SHIFT are data, not resync.
- A tick in the WRITE cycle is accepted as byte 0 of the next word, not dropped. If WRITE exits to DONE, that tick is ignored.
- `load_ack` outside DONE ignored.
- Timeout: timer runs in SHIFT/WRITE and clears on every accepted tick. After `TIMEOUT_CYC` consecutive cycles without a tick, `frame_err` pulses for one cycle and the state returns to IDLE. The partial word is discarded and the address is reset to 0. Words already written are not rescinded. No timeout in IDLE or DONE.
- Timer width is `$clog2(TIMEOUT_CYC+1)`. The byte counter wraps at `BYTES_PER_WORD`.

## Timing
- Final byte of a word sampled in cycle N -> `wr_en`=1 with valid `wr_addr`/`wr_data` in cycle N+1 only.
- Last word's WRITE in cycle M -> `load_done`=1 from cycle M+1.
- `load_ack` sampled in cycle K during DONE -> `load_done`=0 and IDLE in K+1. A `SYNC_BYTE` in K+1 starts a new frame.
- `wr_addr`/`wr_data` hold their last values between strobes.
- `rst` mid-frame: immediate return to IDLE, all outputs 0, no `wr_en` or `frame_err` generated.

## Structure
- Shared package `uart_loader_pkg`: state encoding localparams (IDLE, SHIFT, WRITE, DONE) and the default `SYNC_BYTE`.
- Sub-module `byte_timeout_timer`: clear/enable inputs, parameter `TIMEOUT_CYC`, one-cycle `expired` output.
- The FSM, shift register, byte counter and address counter stay in the top module.

## Test plan
- Parameters `WORD_W`=32, `NUM_WORDS`=2. Send A5,12,34,56,78,9A,BC,DE,F0 -> `wr_en` addr 0 data 32'h12345678, then addr 1 data 32'h9ABCDEF0. `load_done`=1 the cycle after the second write, held until `load_ack`.
- In IDLE, send 00,FF,5A, then a full frame -> no writes until after A5; writes start at addr 0.
- Send A5,11,22, then idle for `TIMEOUT_CYC` cycles -> `frame_err` pulses once, no `wr_en`. Next frame writes data starting at addr 0.
- Payload containing A5 (A5,A5,00,00,01,...) -> first word 32'hA5000001. No resync.
- Send bytes while in DONE, then assert `load_ack` -> bytes ignored, no `wr_en`, `load_done` clears the next cycle, new frame accepted.
- Assert `rst` after 3 payload bytes -> all outputs 0 immediately, no write. A subsequent full frame writes correctly from addr 0.

Source files
------------

// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader_pkg
// Description : Shared definitions for the UART receive-side operand loader.
//               Holds the FSM state encoding and the default frame sync byte.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

    // FSM state encoding, kept as plain constants so older code that
    // compares raw state values keeps working.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Default frame start marker.
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/rx_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_operand_loader_if
// Description : Bundle between the UART receiver / operand memory / sequencer
//               and the operand loader.
// Ports       : rx_done_tick, rx_data  - byte strobe and byte from UART RX
//               load_ack               - sequencer has taken the frame
//               wr_en, wr_addr, wr_data- operand memory write port
//               load_done, frame_err   - frame status
//               modport master: the loader; modport slave: its environment
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_operand_loader_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 4
);
    logic              rx_done_tick;
    logic [7:0]        rx_data;
    logic              load_ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              load_done;
    logic              frame_err;

    modport master (
        input  rx_done_tick, rx_data, load_ack,
        output wr_en, wr_addr, wr_data, load_done, frame_err
    );

    modport slave (
        output rx_done_tick, rx_data, load_ack,
        input  wr_en, wr_addr, wr_data, load_done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/byte_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : byte_timeout_timer
// Description : Counts enabled cycles since the last clear and emits a single
//               registered pulse once TIMEOUT_CYC cycles have elapsed.
// Ports       : clk, rst  - clock, asynchronous active-high reset
//               clear     - restart the count (highest priority)
//               enable    - count this cycle
//               expired   - one-cycle pulse after TIMEOUT_CYC idle cycles
// Revision    : 1.0 - initial release
// ============================================================================
module byte_timeout_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (clear || !enable) begin
                count <= '0;
            end else if (count == CNT_W'(TIMEOUT_CYC - 1)) begin
                // Restart so a lingering enable cannot produce a second pulse
                // back-to-back with the first.
                count   <= '0;
                expired <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rx_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : rx_operand_loader
// Description : Waits for a sync byte, packs received bytes MSB-first into
//               operand words and writes NUM_WORDS words sequentially into
//               the operand memory. Raises load_done until acknowledged.
//               An inter-byte timeout abandons a partial frame.
// Ports       : clk, rst  - clock, asynchronous active-high reset
//               bus       - rx_operand_loader_if master modport
// Revision    : 1.0 - initial release
// ============================================================================
module rx_operand_loader
    import uart_loader_pkg::*;
#(
    parameter int         WORD_W      = 32,
    parameter int         ADDR_W      = 4,
    parameter int         NUM_WORDS   = 16,
    parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 100000
) (
    input wire logic               clk,
    input wire logic               rst,
    rx_operand_loader_if.master    bus
);
    localparam int BYTES_PER_WORD = WORD_W / 8;
    localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    logic [1:0]        state;
    logic [BCNT_W-1:0] byte_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] shift_next;
    logic [ADDR_W-1:0] next_wr_addr;
    logic              in_frame;
    logic              last_addr;
    logic              word_done;
    logic              accept;
    logic              expired;

    assign in_frame  = (state == ST_SHIFT) || (state == ST_WRITE);
    assign last_addr = (addr_cnt == ADDR_W'(NUM_WORDS - 1));
    assign word_done = (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));

    // A tick during WRITE belongs to the next word unless this WRITE ends
    // the frame; a timeout takes precedence over any coincident tick.
    assign accept = bus.rx_done_tick && !expired &&
                    ((state == ST_SHIFT) || ((state == ST_WRITE) && !last_addr));

    // addr_cnt advances at the end of WRITE, so a word completing inside
    // WRITE (single-byte words) targets the following address.
    assign next_wr_addr = (state == ST_WRITE) ? addr_cnt + 1'b1 : addr_cnt;

    generate
        if (WORD_W == 8) begin : g_shift_byte
            assign shift_next = bus.rx_data;
        end else begin : g_shift_wide
            assign shift_next = {shift_reg[WORD_W-9:0], bus.rx_data};
        end
    endgenerate

    byte_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_frame || accept),
        .enable  (in_frame),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            byte_cnt      <= '0;
            addr_cnt      <= '0;
            shift_reg     <= '0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.load_done <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.wr_en     <= 1'b0;
            bus.frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rx_done_tick && (bus.rx_data == SYNC_BYTE)) begin
                        state    <= ST_SHIFT;
                        byte_cnt <= '0;
                        addr_cnt <= '0;
                    end
                end
                ST_SHIFT, ST_WRITE: begin
                    if (state == ST_WRITE) begin
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                    if (expired) begin
                        // Drop the partial word; earlier writes stand.
                        bus.frame_err <= 1'b1;
                        state         <= ST_IDLE;
                        byte_cnt      <= '0;
                        addr_cnt      <= '0;
                    end else if ((state == ST_WRITE) && last_addr) begin
                        state         <= ST_DONE;
                        bus.load_done <= 1'b1;
                    end else if (accept) begin
                        shift_reg <= shift_next;
                        if (word_done) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= next_wr_addr;
                            bus.wr_data <= shift_next;
                            byte_cnt    <= '0;
                            state       <= ST_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= ST_SHIFT;
                        end
                    end else if (state == ST_WRITE) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (bus.load_ack) begin
                        bus.load_done <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rx_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_operand_loader
// Description : Directed self-checking bench for rx_operand_loader with
//               32-bit words, two words per frame and a short timeout.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_operand_loader;
    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 4;
    localparam int NUM_WORDS   = 2;
    localparam int TIMEOUT_CYC = 20;

    logic clk;
    logic rst;

    int n_vec  = 0;
    int n_err  = 0;
    int n_ferr = 0;
    logic [ADDR_W-1:0] wa[$];
    logic [WORD_W-1:0] wd[$];

    rx_operand_loader_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    rx_operand_loader #(
        .WORD_W      (WORD_W),
        .ADDR_W      (ADDR_W),
        .NUM_WORDS   (NUM_WORDS),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe and error pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
        end
        if (bus.frame_err) n_ferr++;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data      = b;
        bus.rx_done_tick = 1'b1;
        @(negedge clk);
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1);
        send_byte(8'hA5);
        send_word(w0);
        send_word(w1);
    endtask

    task automatic expect_frame(input string tag, input int base,
                                input logic [31:0] w0, input logic [31:0] w1);
        check_val({tag, "_nwr"}, 64'(wa.size()), 64'(base + 2));
        if (wa.size() >= base + 2) begin
            check_val({tag, "_a0"}, 64'(wa[base]),     64'd0);
            check_val({tag, "_d0"}, 64'(wd[base]),     64'(w0));
            check_val({tag, "_a1"}, 64'(wa[base + 1]), 64'd1);
            check_val({tag, "_d1"}, 64'(wd[base + 1]), 64'(w1));
        end
    endtask

    task automatic do_ack(input string tag);
        bus.load_ack = 1'b1;
        @(negedge clk);
        bus.load_ack = 1'b0;
        check_val({tag, "_done_clr"}, 64'(bus.load_done), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_wr_en"},  64'(bus.wr_en),     64'd0);
        check_val({tag, "_addr"},   64'(bus.wr_addr),   64'd0);
        check_val({tag, "_data"},   64'(bus.wr_data),   64'd0);
        check_val({tag, "_done"},   64'(bus.load_done), 64'd0);
        check_val({tag, "_ferr"},   64'(bus.frame_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ferr0;
        rst              = 1'b1;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        bus.load_ack     = 1'b0;
        idle(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        idle(2);

        // Basic frame, back-to-back bytes (a tick lands in the WRITE cycle).
        send_frame(32'h12345678, 32'h9ABCDEF0);
        check_val("t2_wr_en",  64'(bus.wr_en),   64'd1);
        check_val("t2_wr_adr", 64'(bus.wr_addr), 64'd1);
        check_val("t2_wr_dat", 64'(bus.wr_data), 64'h9ABCDEF0);
        @(negedge clk);
        check_val("t2_done",   64'(bus.load_done), 64'd1);
        check_val("t2_wr_off", 64'(bus.wr_en),     64'd0);
        idle(5);
        check_val("t2_hold",   64'(bus.load_done), 64'd1);
        check_val("t2_dat_hold", 64'(bus.wr_data), 64'h9ABCDEF0);
        expect_frame("t2", 0, 32'h12345678, 32'h9ABCDEF0);
        do_ack("t2");

        // Junk in IDLE is ignored, frame starts at address 0.
        base = wa.size();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        idle(3);
        check_val("t3_no_wr", 64'(wa.size()), 64'(base));
        send_frame(32'h01020304, 32'h05060708);
        idle(3);
        expect_frame("t3", base, 32'h01020304, 32'h05060708);
        do_ack("t3");

        // Partial frame times out.
        base  = wa.size();
        ferr0 = n_ferr;
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
        idle(TIMEOUT_CYC + 6);
        check_val("t4_ferr", 64'(n_ferr - ferr0), 64'd1);
        check_val("t4_no_wr", 64'(wa.size()), 64'(base));
        send_frame(32'hAABBCCDD, 32'h11223344);
        idle(3);
        expect_frame("t4", base, 32'hAABBCCDD, 32'h11223344);
        do_ack("t4");

        // Sync byte inside payload is data.
        base = wa.size();
        send_frame(32'hA5000001, 32'h02030405);
        idle(3);
        expect_frame("t5", base, 32'hA5000001, 32'h02030405);

        // Bytes during DONE are ignored; new frame accepted right after ack.
        base = wa.size();
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78);
        idle(2);
        check_val("t6_no_wr", 64'(wa.size()), 64'(base));
        check_val("t6_done",  64'(bus.load_done), 64'd1);
        do_ack("t6");
        send_frame(32'hCAFEF00D, 32'hDEADBEEF);
        idle(3);
        expect_frame("t6", base, 32'hCAFEF00D, 32'hDEADBEEF);
        do_ack("t6b");

        // Reset mid-frame.
        base  = wa.size();
        ferr0 = n_ferr;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        rst = 1'b1;
        #1;
        check_outputs_zero("t7_rst");
        @(negedge clk);
        rst = 1'b0;
        idle(TIMEOUT_CYC + 4);
        check_val("t7_no_wr",   64'(wa.size()), 64'(base));
        check_val("t7_no_ferr", 64'(n_ferr - ferr0), 64'd0);
        send_frame(32'h76543210, 32'h89ABCDEF);
        idle(3);
        expect_frame("t7", base, 32'h76543210, 32'h89ABCDEF);
        do_ack("t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
